// File: rtl/tri_job_sched.sv
// tri_job_sched: job scheduler in front of the right-angled triangle engine.
//
// Accepts triangle jobs from NREQ requesters and picks one at a time,
// round-robin. For the chosen job it resets the engine and streams the three
// vertices. It then waits for the engine to go busy and forwards every
// rendered pixel, tagged with the owning requester. It finishes with a
// per-requester done pulse, or an err pulse if the engine times out.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req, req_vtx        per-requester job request and {x0,y0,x1,y1,x2,y2}
//   gnt, done, err      one-cycle pulses: job accepted / finished / timed out
//   pix_cnt, idle       pixels counted for current/last job, idle status
//   eng_rst, eng_nt     engine reset and new-triangle strobe
//   eng_xi, eng_yi      vertex presented to the engine
//   eng_busy, eng_po    engine busy and pixel-valid
//   eng_xo, eng_yo      engine pixel coordinates
//   pix_valid, pix_x,
//   pix_y, pix_id       registered forward of each counted pixel
module tri_job_sched #(
    parameter int NREQ     = 2,
    parameter int WAIT_MAX = 15,
    parameter int RUN_MAX  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*18-1:0]   req_vtx,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [6:0]           pix_cnt,
    output logic                 idle,
    output logic                 eng_rst,
    output logic                 eng_nt,
    output logic [2:0]           eng_xi,
    output logic [2:0]           eng_yi,
    input  logic                 eng_busy,
    input  logic                 eng_po,
    input  logic [2:0]           eng_xo,
    input  logic [2:0]           eng_yo,
    output logic                 pix_valid,
    output logic [2:0]           pix_x,
    output logic [2:0]           pix_y,
    output logic [1:0]           pix_id
);

    localparam int IW   = 2;
    localparam int TMAX = (WAIT_MAX > RUN_MAX) ? WAIT_MAX : RUN_MAX;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] WAIT_LIM = TW'(WAIT_MAX);
    localparam logic [TW-1:0] RUN_LIM  = TW'(RUN_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_ERST, S_LOAD0, S_LOAD1, S_LOAD2, S_WAIT, S_RUN, S_DONE
    } state_t;

    function automatic logic [6:0] sat_inc(input logic [6:0] c);
        return (c >= 7'd64) ? 7'd64 : c + 7'd1;
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    id_q, id_d;
    logic [17:0]      vtx_q, vtx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             err_q, err_d;
    logic [6:0]       pix_cnt_q, pix_cnt_d;
    logic             idle_q, idle_d;
    logic             eng_rst_q, eng_rst_d;
    logic             eng_nt_q, eng_nt_d;
    logic [2:0]       eng_xi_q, eng_xi_d;
    logic [2:0]       eng_yi_q, eng_yi_d;
    logic             pix_valid_q, pix_valid_d;
    logic [2:0]       pix_x_q, pix_x_d;
    logic [2:0]       pix_y_q, pix_y_d;
    logic [1:0]       pix_id_q, pix_id_d;

    // Round-robin search starting just after the last granted requester.
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    rr_idx;
    logic [17:0]      vtx_sel;
    logic [TW-1:0]    timer_inc;

    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = IW'((int'(ptr_q) + i) % NREQ);
            for (int r = 0; r < NREQ; r++) begin
                if (!found && req[r] && (rr_idx == IW'(r))) begin
                    found = 1'b1;
                    pick  = rr_idx;
                end
            end
        end
        vtx_sel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pick == IW'(r)) vtx_sel = req_vtx[r*18 +: 18];
        end
    end

    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        vtx_d       = vtx_q;
        timer_d     = timer_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        pix_cnt_d   = pix_cnt_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_id_d    = pix_id_q;

        // Engine-side strobes follow the state one cycle later, so the
        // sequence seen by the engine is gnt, eng_rst, eng_nt+v0, v1, v2.
        eng_rst_d = (state_q == S_ERST);
        eng_nt_d  = (state_q == S_LOAD0);
        case (state_q)
            S_LOAD0: begin eng_xi_d = vtx_q[17:15]; eng_yi_d = vtx_q[14:12]; end
            S_LOAD1: begin eng_xi_d = vtx_q[11:9];  eng_yi_d = vtx_q[8:6];   end
            S_LOAD2: begin eng_xi_d = vtx_q[5:3];   eng_yi_d = vtx_q[2:0];   end
            default: begin eng_xi_d = 3'd0;         eng_yi_d = 3'd0;         end
        endcase

        // Pixels are taken in RUN and also in DONE, so one arriving as busy
        // falls is still forwarded and counted.
        if (((state_q == S_RUN) || (state_q == S_DONE)) && eng_po) begin
            pix_valid_d = 1'b1;
            pix_x_d     = eng_xo;
            pix_y_d     = eng_yo;
            pix_id_d    = id_q;
            pix_cnt_d   = sat_inc(pix_cnt_q);
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (found) begin
                    id_d      = pick;
                    ptr_d     = pick;
                    vtx_d     = vtx_sel;
                    pix_cnt_d = 7'd0;
                    for (int r = 0; r < NREQ; r++) gnt_d[r] = (pick == IW'(r));
                    state_d   = S_ERST;
                end
            end
            S_ERST:  state_d = S_LOAD0;
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            // The limit is tested on the incremented count, so WAIT and RUN
            // each last at most WAIT_MAX / RUN_MAX cycles.
            S_WAIT: begin
                if (eng_busy) begin
                    timer_d = '0;
                    state_d = S_RUN;
                end else if (timer_inc == WAIT_LIM) begin
                    err_d     = 1'b1;
                    eng_rst_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RUN: begin
                if (!eng_busy) begin
                    timer_d = '0;
                    state_d = S_DONE;
                end else if (timer_inc == RUN_LIM) begin
                    err_d     = 1'b1;
                    eng_rst_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DONE: begin
                for (int r = 0; r < NREQ; r++) done_d[r] = (id_q == IW'(r));
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(NREQ - 1);
            id_q        <= '0;
            vtx_q       <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            pix_cnt_q   <= 7'd0;
            idle_q      <= 1'b1;
            eng_rst_q   <= 1'b0;
            eng_nt_q    <= 1'b0;
            eng_xi_q    <= 3'd0;
            eng_yi_q    <= 3'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 3'd0;
            pix_y_q     <= 3'd0;
            pix_id_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            vtx_q       <= vtx_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pix_cnt_q   <= pix_cnt_d;
            idle_q      <= idle_d;
            eng_rst_q   <= eng_rst_d;
            eng_nt_q    <= eng_nt_d;
            eng_xi_q    <= eng_xi_d;
            eng_yi_q    <= eng_yi_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_id_q    <= pix_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pix_cnt   = pix_cnt_q;
    assign idle      = idle_q;
    assign eng_rst   = eng_rst_q;
    assign eng_nt    = eng_nt_q;
    assign eng_xi    = eng_xi_q;
    assign eng_yi    = eng_yi_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_id    = pix_id_q;

endmodule

// File: tb/tb_tri_job_sched.sv
// tb_tri_job_sched: directed bench for tri_job_sched (NREQ = 2). The engine
// is played directly by the bench through eng_busy / eng_po / eng_xo / eng_yo.
module tb_tri_job_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [35:0] req_vtx = '0;
    logic [1:0]  gnt, done;
    logic        err, idle, eng_rst, eng_nt, pix_valid;
    logic [6:0]  pix_cnt;
    logic [2:0]  eng_xi, eng_yi, pix_x, pix_y;
    logic        eng_busy = 1'b0, eng_po = 1'b0;
    logic [2:0]  eng_xo = '0, eng_yo = '0;
    logic [1:0]  pix_id;

    int checks = 0;
    int failures = 0;

    tri_job_sched #(.NREQ(2), .WAIT_MAX(15), .RUN_MAX(255)) dut (
        .clk(clk), .reset(reset), .req(req), .req_vtx(req_vtx),
        .gnt(gnt), .done(done), .err(err), .pix_cnt(pix_cnt), .idle(idle),
        .eng_rst(eng_rst), .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi),
        .eng_busy(eng_busy), .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises req, waits (bounded) for a grant, then walks to the first WAIT
    // cycle. rst_ok reports eng_rst then eng_nt on the two cycles after gnt.
    task automatic start_job(input logic [1:0] r, input bit hold,
                             output int gid, output bit ok, output bit rst_ok);
        ok = 1'b0; gid = -1; rst_ok = 1'b0;
        req = r;
        for (int i = 0; i < 8 && !ok; i++) begin
            step();
            if (gnt !== 2'b00) ok = 1'b1;
        end
        if (ok) begin
            gid = (gnt === 2'b01) ? 0 : (gnt === 2'b10) ? 1 : 9;
            if (!hold) req = '0;
            step(); rst_ok = (eng_rst === 1'b1);
            step(); rst_ok = rst_ok && (eng_nt === 1'b1);
            step();
            step();
        end else begin
            req = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (idle !== 1'b1) begin
            failures++; $display("FAIL reset_idle: got %b expected 1", idle);
        end
        checks++;
        if ({gnt, done, err, pix_cnt, eng_rst, eng_nt, eng_xi, eng_yi,
             pix_valid, pix_x, pix_y, pix_id} !== 29'd0) begin
            failures++; $display("FAIL reset_outputs: got gnt=%b done=%b err=%b cnt=%0d expected all 0",
                                 gnt, done, err, pix_cnt);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_arbitration();
        int gid; bit ok; bit rok; int npix; int bad;
        req_vtx = {18'h12345, 18'h0ABCD};
        for (int k = 0; k < 4; k++) begin
            start_job(2'b11, 1'b1, gid, ok, rok);
            checks++;
            if (!ok || gid !== (k % 2)) begin
                failures++; $display("FAIL arb_grant%0d: got id %0d expected %0d", k, gid, k % 2);
            end
            eng_busy = 1'b1; step();
            npix = 0; bad = 0;
            for (int p = 0; p <= k; p++) begin
                eng_po = 1'b1; eng_xo = 3'(p); eng_yo = 3'(k);
                step();
                if (pix_valid === 1'b1) npix++;
                if (pix_id !== 2'(k % 2) || pix_x !== 3'(p)) bad++;
            end
            eng_po = 1'b0; eng_busy = 1'b0;
            step();
            step();
            checks++;
            if (done !== (2'b01 << (k % 2)) || npix != k + 1 || bad != 0) begin
                failures++; $display("FAIL arb_done%0d: got done=%b pix=%0d bad=%0d expected done=%b pix=%0d",
                                     k, done, npix, bad, 2'b01 << (k % 2), k + 1);
            end
            checks++;
            if (pix_cnt !== 7'(k + 1)) begin
                failures++; $display("FAIL arb_cnt%0d: got %0d expected %0d", k, pix_cnt, k + 1);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_single_job();
        int npix; int bad;
        req_vtx = {18'h3FFFF, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3};
        req = 2'b01;
        step();
        checks++;
        if (gnt !== 2'b01 || idle !== 1'b0 || pix_cnt !== 7'd0 || eng_rst !== 1'b0) begin
            failures++; $display("FAIL single_gnt: got gnt=%b idle=%b cnt=%0d rst=%b expected 01 0 0 0",
                                 gnt, idle, pix_cnt, eng_rst);
        end
        req = '0;
        req_vtx[17:0] = 18'h2AAAA;
        step();
        checks++;
        if (eng_rst !== 1'b1 || eng_nt !== 1'b0 || gnt !== 2'b00) begin
            failures++; $display("FAIL single_engrst: got rst=%b nt=%b gnt=%b expected 1 0 00", eng_rst, eng_nt, gnt);
        end
        step();
        checks++;
        if (eng_nt !== 1'b1 || eng_rst !== 1'b0 || {eng_xi, eng_yi} !== 6'o00) begin
            failures++; $display("FAIL single_v0: got nt=%b rst=%b v=(%0d,%0d) expected 1 0 (0,0)",
                                 eng_nt, eng_rst, eng_xi, eng_yi);
        end
        step();
        checks++;
        if (eng_nt !== 1'b0 || {eng_xi, eng_yi} !== 6'o30) begin
            failures++; $display("FAIL single_v1: got nt=%b v=(%0d,%0d) expected 0 (3,0)", eng_nt, eng_xi, eng_yi);
        end
        step();
        checks++;
        if (eng_nt !== 1'b0 || {eng_xi, eng_yi} !== 6'o03) begin
            failures++; $display("FAIL single_v2: got nt=%b v=(%0d,%0d) expected 0 (0,3)", eng_nt, eng_xi, eng_yi);
        end
        eng_busy = 1'b1;
        step();
        checks++;
        if ({eng_xi, eng_yi} !== 6'o00) begin
            failures++; $display("FAIL single_vclr: got (%0d,%0d) expected (0,0)", eng_xi, eng_yi);
        end
        npix = 0; bad = 0;
        for (int k = 0; k < 10; k++) begin
            eng_po = 1'b1; eng_xo = 3'(k % 8); eng_yo = 3'((k + 3) % 8);
            step();
            if (pix_valid === 1'b1) npix++;
            if (pix_x !== 3'(k % 8) || pix_y !== 3'((k + 3) % 8) || pix_id !== 2'd0) bad++;
        end
        checks++;
        if (npix != 10 || bad != 0) begin
            failures++; $display("FAIL single_pixels: got %0d valid, %0d wrong expected 10 valid, 0 wrong", npix, bad);
        end
        eng_po = 1'b0; eng_busy = 1'b0;
        step();
        checks++;
        if (done !== 2'b00 || pix_valid !== 1'b0) begin
            failures++; $display("FAIL single_early_done: got done=%b pv=%b expected 00 0", done, pix_valid);
        end
        step();
        checks++;
        if (done !== 2'b01 || idle !== 1'b1 || pix_cnt !== 7'd10) begin
            failures++; $display("FAIL single_done: got done=%b idle=%b cnt=%0d expected 01 1 10", done, idle, pix_cnt);
        end
        step();
        checks++;
        if (done !== 2'b00 || pix_cnt !== 7'd10) begin
            failures++; $display("FAIL single_hold: got done=%b cnt=%0d expected 00 10", done, pix_cnt);
        end
    endtask

    task automatic test_wait_timeout();
        int gid; bit ok; bit rok;
        start_job(2'b01, 1'b0, gid, ok, rok);
        checks++;
        if (!ok || gid !== 0 || !rok) begin
            failures++; $display("FAIL wto_start: got ok=%b id=%0d rst_nt=%b expected 1 0 1", ok, gid, rok);
        end
        repeat (14) step();
        checks++;
        if (err !== 1'b0 || idle !== 1'b0) begin
            failures++; $display("FAIL wto_early: got err=%b idle=%b expected 0 0", err, idle);
        end
        step();
        checks++;
        if (err !== 1'b1 || eng_rst !== 1'b1 || idle !== 1'b1 || done !== 2'b00) begin
            failures++; $display("FAIL wto_err: got err=%b rst=%b idle=%b done=%b expected 1 1 1 00",
                                 err, eng_rst, idle, done);
        end
        step();
        checks++;
        if (err !== 1'b0 || eng_rst !== 1'b0 || done !== 2'b00) begin
            failures++; $display("FAIL wto_after: got err=%b rst=%b done=%b expected 0 0 00", err, eng_rst, done);
        end
    endtask

    task automatic test_last_pixel();
        int gid; bit ok; bit rok;
        start_job(2'b01, 1'b0, gid, ok, rok);
        eng_busy = 1'b1; step();
        eng_po = 1'b1; eng_xo = 3'd2; eng_yo = 3'd1;
        step();
        eng_busy = 1'b0; eng_xo = 3'd7; eng_yo = 3'd5;
        step();
        checks++;
        if (pix_valid !== 1'b1 || {pix_x, pix_y} !== 6'o75 || done !== 2'b00) begin
            failures++; $display("FAIL last_fall_pix: got pv=%b (%0d,%0d) done=%b expected 1 (7,5) 00",
                                 pix_valid, pix_x, pix_y, done);
        end
        eng_xo = 3'd4; eng_yo = 3'd4;
        step();
        checks++;
        if (done !== 2'b01 || pix_valid !== 1'b1 || {pix_x, pix_y} !== 6'o44 || pix_cnt !== 7'd3) begin
            failures++; $display("FAIL last_done_pix: got done=%b pv=%b (%0d,%0d) cnt=%0d expected 01 1 (4,4) 3",
                                 done, pix_valid, pix_x, pix_y, pix_cnt);
        end
        eng_po = 1'b0;
        step();
        checks++;
        if (pix_valid !== 1'b0 || pix_cnt !== 7'd3) begin
            failures++; $display("FAIL last_after: got pv=%b cnt=%0d expected 0 3", pix_valid, pix_cnt);
        end
    endtask

    task automatic test_saturation_run_timeout();
        int gid; bit ok; bit rok; int n;
        start_job(2'b10, 1'b0, gid, ok, rok);
        checks++;
        if (!ok || gid !== 1) begin
            failures++; $display("FAIL sat_start: got ok=%b id=%0d expected 1 1", ok, gid);
        end
        eng_busy = 1'b1; step();
        eng_po = 1'b1; eng_xo = 3'd1; eng_yo = 3'd2;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 63) begin
                checks++;
                if (pix_cnt !== 7'd63) begin
                    failures++; $display("FAIL sat_63: got %0d expected 63", pix_cnt);
                end
            end
        end
        checks++;
        if (pix_cnt !== 7'd64 || pix_id !== 2'd1 || pix_valid !== 1'b1) begin
            failures++; $display("FAIL sat_64: got cnt=%0d id=%0d pv=%b expected 64 1 1", pix_cnt, pix_id, pix_valid);
        end
        eng_po = 1'b0;
        n = 70;
        while (err !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (err !== 1'b1 || n != 255) begin
            failures++; $display("FAIL run_timeout: got err=%b after %0d RUN cycles expected 1 after 255", err, n);
        end
        checks++;
        if (eng_rst !== 1'b1 || idle !== 1'b1 || done !== 2'b00 || pix_cnt !== 7'd64) begin
            failures++; $display("FAIL run_timeout_state: got rst=%b idle=%b done=%b cnt=%0d expected 1 1 00 64",
                                 eng_rst, idle, done, pix_cnt);
        end
        eng_busy = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int gid; bit ok; bit rok;
        start_job(2'b01, 1'b0, gid, ok, rok);
        eng_busy = 1'b1; step();
        eng_po = 1'b1; eng_xo = 3'd3; eng_yo = 3'd3;
        step();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1 || {gnt, done, err, pix_cnt, eng_rst, eng_nt, eng_xi, eng_yi,
                               pix_valid, pix_x, pix_y, pix_id} !== 29'd0) begin
            failures++; $display("FAIL async_reset: got idle=%b pv=%b cnt=%0d err=%b expected 1 0 0 0",
                                 idle, pix_valid, pix_cnt, err);
        end
        eng_po = 1'b0; eng_busy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start_job(2'b10, 1'b0, gid, ok, rok);
        checks++;
        if (!ok || gid !== 1 || !rok) begin
            failures++; $display("FAIL post_reset_job: got ok=%b id=%0d rst_nt=%b expected 1 1 1", ok, gid, rok);
        end
        eng_busy = 1'b1; step();
        eng_busy = 1'b0; step();
        step();
        checks++;
        if (done !== 2'b10 || err !== 1'b0) begin
            failures++; $display("FAIL post_reset_done: got done=%b err=%b expected 10 0", done, err);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_job();
        test_wait_timeout();
        test_last_pixel();
        test_saturation_run_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tri_job_sched.md
Name: tri_job_sched

Overview:
- Job scheduler in front of the right-angled triangle rendering engine.
- Accepts triangle jobs (three 3-bit vertex pairs) from NREQ requesters and arbitrates round-robin.
- Per job: resets the engine, streams the three vertices, monitors busy, and forwards/counts rendered pixels tagged with the requester id.
- Reports per-requester completion, or a timeout error.

Parameters:
NREQ, 2, number of requesters (2..4); ID width IW = 2.
WAIT_MAX, 15, max cycles in WAIT for eng_busy to rise before error.
RUN_MAX, 255, max cycles in RUN before error.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
req  in  NREQ  job request per requester; held until its gnt bit
req_vtx  in  NREQ*18  per requester {x0,y0,x1,y1,x2,y2}, 3 bits each, requester 0 in LSBs
gnt  out  NREQ  one-hot, 1-cycle pulse when job accepted
done  out  NREQ  one-hot, 1-cycle pulse at job completion
err  out  1  1-cycle pulse on timeout
pix_cnt  out  7  pixels counted for current/last job (0..64)
idle  out  1  high in IDLE
eng_rst  out  1  active-high engine reset
eng_nt  out  1  new-triangle strobe
eng_xi, eng_yi  out  3 each  vertex to engine
eng_busy, eng_po  in  1 each  engine status / pixel valid
eng_xo, eng_yo  in  3 each  engine pixel coordinates
pix_valid  out  1  registered forward of a counted pixel
pix_x, pix_y  out  3 each  forwarded coordinates
pix_id  out  IW  requester owning the pixel

Behaviour:
- Reset values (reset low, asynchronous):
  - State = IDLE; idle = 1.
  - All other outputs = 0.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - Timer = 0.
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer+1 mod NREQ.
  - On grant: latch that requester's req_vtx and id, pulse gnt[id], set pointer = id, clear pix_cnt, go to ERST.
  - No req: stay in IDLE.
- ERST: eng_rst = 1 for exactly one cycle -> LOAD0.
- LOAD0 / LOAD1 / LOAD2: one cycle each.
  - eng_xi/eng_yi = v0 / v1 / v2.
  - eng_nt = 1 in LOAD0 only.
  - eng_xi/eng_yi = 0 in all other states.
  - LOAD2 -> WAIT.
- WAIT:
  - Timer increments each cycle.
  - eng_busy = 1 -> RUN, timer cleared.
  - Timer == WAIT_MAX with busy still 0 -> err pulse, eng_rst pulse, go to IDLE; no done.
- RUN:
  - Timer increments each cycle.
  - Each cycle with eng_po = 1: next cycle pix_valid = 1 with pix_x/pix_y = eng_xo/eng_yo and pix_id = id; pix_cnt += 1, saturating at 64.
  - eng_busy = 0 -> DONE.
  - Timer == RUN_MAX -> err pulse, eng_rst pulse, IDLE.
- DONE:
  - eng_po is still sampled, so a pixel coincident with busy falling is counted.
  - done[id] pulses one cycle.
  - pix_cnt is held from DONE until the next grant.
  - -> IDLE.
- Latency:
  - gnt to eng_nt: 2 cycles.
  - eng_po to pix_valid: 1 cycle.
- Only one job is in flight; req is ignored outside IDLE.
- A requester may drop req after gnt. req still high after done is treated as a new job.
- req_vtx changes after gnt do not affect the running job.
- Simultaneous requests: strict round-robin; no requester is granted twice while another waits.
- Reset asserted mid-job: immediate return to IDLE, no done or err. Engine state is cleaned by the ERST of the next job.

Test Plan:
- Single job: req[0] with v0=(0,0), v1=(3,0), v2=(0,3) -> gnt[0], eng_rst, then eng_nt with (0,0), (3,0), (0,3) on 3 consecutive cycles. Engine model produces 10 po -> 10 pix_valid with pix_id=0, done[0], pix_cnt=10.
- Arbitration: req=2'b11 held continuously -> grants alternate 0,1,0,1 across 4 jobs; each done matches the preceding gnt.
- WAIT timeout: engine model never raises busy -> err after 15 WAIT cycles, eng_rst pulse, no done, idle=1.
- Last-pixel edge: po asserted in the same cycle busy drops -> pixel forwarded, pix_cnt includes it.
- Saturation and run timeout: 70 po pulses -> pix_cnt=64. busy held high for 255 RUN cycles -> err.
- Async reset mid-RUN: all outputs 0 immediately, idle=1. Next req[1] is granted normally with a fresh eng_rst.
